ysyx_22040125_mem_arbiter: RTL and testbench

Two-requester arbiter that shares a single memory port between instruction fetch (IF) and load/store (LS) in the multi-cycle core. It grants one requester at a time round-robin, drives the memory port with a registered request, and routes the single response back to the owner. Exactly one transaction is outstanding at any time.

---
 rtl/ysyx_22040125_mem_arbiter_pkg.sv | 13 +
 rtl/ysyx_22040125_rr_pick.sv | 20 ++
 rtl/ysyx_22040125_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_ysyx_22040125_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040125_mem_arbiter_pkg.sv
// Shared constants for the IF/LS memory arbiter: FSM state and owner encodings.
package ysyx_22040125_mem_arbiter_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Owner encodings; also the bit index of each requester in the picker vectors
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/ysyx_22040125_rr_pick.sv
// Combinational 2-way round-robin picker. req[0]/grant[0] is requester 0 (IF),
// req[1]/grant[1] is requester 1 (LS). On a tie the requester that did not win
// last time is granted. Holds no state; the caller keeps 'last'.
module ysyx_22040125_rr_pick
    import ysyx_22040125_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Single requester wins outright; a tie goes to the one that is not 'last'
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == OWN_LS) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_22040125_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction outstanding at a time; the memory request is registered and
// the single response is routed back to the requester that owns it.
module ysyx_22040125_mem_arbiter
    import ysyx_22040125_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_rdata,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_req_addr,
    input  logic                  ls_req_wen,
    input  logic [DATA_W-1:0]     ls_req_wdata,
    input  logic [DATA_W/8-1:0]   ls_req_wmask,
    output logic                  ls_rsp_valid,
    output logic [DATA_W-1:0]     ls_rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    output logic                  busy
);

    localparam int MASK_W = DATA_W / 8;

    logic [1:0] state;
    logic       owner;
    logic       last_owner;
    logic [1:0] grant;
    logic       if_acc;
    logic       ls_acc;

    ysyx_22040125_rr_pick u_pick (
        .req   ({ls_req_valid, if_req_valid}),
        .last  (last_owner),
        .grant (grant)
    );

    // Ready only in IDLE and only to the picked requester; depends on requester
    // valids and local state, never on the memory side
    always_comb begin
        if_req_ready = rst && (state == ST_IDLE) && grant[0];
        ls_req_ready = rst && (state == ST_IDLE) && grant[1];
        if_acc       = if_req_valid && if_req_ready;
        ls_acc       = ls_req_valid && ls_req_ready;
        busy         = (state != ST_IDLE);
    end

    // FSM, latched memory request payload and response routing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_IF;
            last_owner    <= OWN_LS;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_rdata  <= '0;
            ls_rsp_valid  <= 1'b0;
            ls_rsp_rdata  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ls_acc) begin
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        owner         <= OWN_LS;
                        last_owner    <= OWN_LS;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_wen   <= ls_req_wen;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_wmask <= ls_req_wmask;
                    end else if (if_acc) begin
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        owner         <= OWN_IF;
                        last_owner    <= OWN_IF;
                        mem_req_addr  <= if_req_addr;
                        mem_req_wen   <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= {MASK_W{1'b0}};
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state         <= ST_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= ST_IDLE;
                        if (owner == OWN_LS) begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_rdata <= mem_rsp_rdata;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_rdata <= mem_rsp_rdata;
                        end
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_mem_arbiter.sv
// Directed bench for the IF/LS memory arbiter.
module tb_ysyx_22040125_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_req_addr = '0;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic [31:0] ls_req_addr = '0;
    logic        ls_req_wen = 1'b0;
    logic [63:0] ls_req_wdata = '0;
    logic [7:0]  ls_req_wmask = '0;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_if_rd = '0;
    logic [63:0] exp_ls_rd = '0;

    ysyx_22040125_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        exp_if_rd = '0;
        exp_ls_rd = '0;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    // Called in an IDLE cycle with request inputs already driven; serves one
    // load with minimum latency and checks routing of the response.
    task automatic serve(input logic exp_ls, input logic [63:0] rd);
        #1;
        chk("if_req_ready", if_req_ready, !exp_ls);
        chk("ls_req_ready", ls_req_ready, exp_ls);
        nxt();
        mem_req_ready = 1'b1;
        #1;
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_addr", mem_req_addr, exp_ls ? ls_req_addr : if_req_addr);
        chk("req_wen", mem_req_wen, 1'b0);
        chk("ready_low_req", {if_req_ready, ls_req_ready}, 2'b00);
        nxt();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd;
        #1;
        chk("req_valid_wait", mem_req_valid, 1'b0);
        chk("busy_wait", busy, 1'b1);
        nxt();
        mem_rsp_valid = 1'b0;
        if (exp_ls) exp_ls_rd = rd; else exp_if_rd = rd;
        #1;
        chk("if_rsp_valid", if_rsp_valid, !exp_ls);
        chk("ls_rsp_valid", ls_rsp_valid, exp_ls);
        chk("if_rsp_rdata", if_rsp_rdata, exp_if_rd);
        chk("ls_rsp_rdata", ls_rsp_rdata, exp_ls_rd);
        chk("busy_done", busy, 1'b0);
    endtask

    initial begin
        // Reset state, with a request pending to show ready is forced low
        if_req_valid = 1'b1;
        #2;
        chk("rst_if_ready", if_req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_if_rdata", if_rsp_rdata, 64'h0);
        if_req_valid = 1'b0;
        do_reset();

        // Single IF fetch, response pulse three cycles after accept
        if_req_valid = 1'b1;
        if_req_addr = 32'h8000_0000;
        serve(1'b0, 64'h0010_0073);
        if_req_valid = 1'b0;
        nxt();
        chk("if_pulse_one", if_rsp_valid, 1'b0);

        // Tie every cycle: IF, LS, IF, LS after reset
        do_reset();
        if_req_valid = 1'b1;
        if_req_addr = 32'h8000_0040;
        ls_req_valid = 1'b1;
        ls_req_addr = 32'h8000_2000;
        ls_req_wen = 1'b0;
        serve(1'b0, 64'h1111_0000_0000_0001);
        serve(1'b1, 64'h2222_0000_0000_0002);
        serve(1'b0, 64'h3333_0000_0000_0003);
        serve(1'b1, 64'h4444_0000_0000_0004);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // Store held off by memory for 5 cycles
        nxt();
        ls_req_valid = 1'b1;
        ls_req_addr = 32'h8000_1000;
        ls_req_wen = 1'b1;
        ls_req_wdata = 64'hDEAD_BEEF;
        ls_req_wmask = 8'h0F;
        #1;
        chk("st_ready", ls_req_ready, 1'b1);
        nxt();
        ls_req_addr = 32'h8000_1FF8;
        ls_req_wdata = 64'h5555;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("st_valid", mem_req_valid, 1'b1);
            chk("st_addr", mem_req_addr, 32'h8000_1000);
            chk("st_wdata", mem_req_wdata, 64'hDEAD_BEEF);
            chk("st_wmask", mem_req_wmask, 8'h0F);
            chk("st_wen", mem_req_wen, 1'b1);
            chk("st_ls_ready", ls_req_ready, 1'b0);
            nxt();
        end
        ls_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("st_valid6", mem_req_valid, 1'b1);
        nxt();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234;
        nxt();
        mem_rsp_valid = 1'b0;
        #1;
        chk("st_rsp", ls_rsp_valid, 1'b1);
        chk("st_rdata", ls_rsp_rdata, 64'h1234);
        chk("st_if_rsp", if_rsp_valid, 1'b0);
        nxt();
        chk("st_rsp_one", ls_rsp_valid, 1'b0);
        ls_req_wen = 1'b0;
        ls_req_wmask = 8'h00;

        // Spurious response in IDLE, then during REQ
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hBAD;
        nxt();
        chk("spur_idle_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        chk("spur_idle_busy", busy, 1'b0);
        mem_rsp_valid = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr = 32'h8000_0100;
        nxt();
        if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        nxt();
        chk("spur_req_rsp", {if_rsp_valid, ls_rsp_valid}, 2'b00);
        chk("spur_req_state", mem_req_valid, 1'b1);
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        nxt();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hABCD;
        nxt();
        mem_rsp_valid = 1'b0;
        #1;
        chk("spur_real_rsp", if_rsp_valid, 1'b1);
        chk("spur_real_rd", if_rsp_rdata, 64'hABCD);

        // Reset while waiting for the response
        nxt();
        if_req_valid = 1'b1;
        if_req_addr = 32'h8000_0200;
        nxt();
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        nxt();
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h7777;
        #1;
        chk("wrst_busy", busy, 1'b0);
        chk("wrst_addr", mem_req_addr, 32'h0);
        chk("wrst_rdata", if_rsp_rdata, 64'h0);
        nxt();
        chk("wrst_rsp", if_rsp_valid, 1'b0);
        rst = 1'b1;
        mem_rsp_valid = 1'b0;
        nxt();
        chk("wrst_after", {if_rsp_valid, ls_rsp_valid, busy}, 3'b000);
        exp_if_rd = '0;
        exp_ls_rd = '0;
        if_req_valid = 1'b1;
        if_req_addr = 32'h8000_0300;
        serve(1'b0, 64'h9999);
        if_req_valid = 1'b0;

        // Requester dropped: no grant, no state change
        nxt();
        #1;
        chk("drop_ready", {if_req_ready, ls_req_ready}, 2'b00);
        nxt();
        chk("drop_busy", busy, 1'b0);
        chk("drop_mem", mem_req_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
